// File: rtl/bgm_pkg.sv
// Shared types and constant tables for the background-music sequencer:
// state encoding, note half-period ROM and the song step table.
package bgm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    PAUSE
  } state_t;

  localparam int unsigned NUM_NOTES = 22;

  // Half-period in 50 MHz clock cycles; index 0 is a rest.
  // 1..7 = C4..B4, 8..14 = C5..B5, 15..21 = C6..B6 (diatonic).
  localparam logic [16:0] HALF_PERIOD [NUM_NOTES] = '{
    17'd0,
    17'd95556, 17'd85132, 17'd75843, 17'd71586, 17'd63776, 17'd56818, 17'd50619,
    17'd47778, 17'd42566, 17'd37921, 17'd35793, 17'd31888, 17'd28409, 17'd25310,
    17'd23889, 17'd21283, 17'd18961, 17'd17897, 17'd15944, 17'd14205, 17'd12655
  };

  // Song table: one note index per step.
  localparam logic [4:0] SONG [64] = '{
    5'd6,  5'd8,  5'd0,  5'd15, 5'd5,  5'd5,  5'd6,  5'd6,
    5'd8,  5'd8,  5'd6,  5'd0,  5'd4,  5'd4,  5'd3,  5'd3,
    5'd2,  5'd2,  5'd1,  5'd0,  5'd5,  5'd5,  5'd4,  5'd4,
    5'd3,  5'd3,  5'd2,  5'd0,  5'd5,  5'd5,  5'd4,  5'd4,
    5'd3,  5'd3,  5'd2,  5'd0,  5'd1,  5'd1,  5'd5,  5'd5,
    5'd6,  5'd6,  5'd5,  5'd0,  5'd4,  5'd4,  5'd3,  5'd3,
    5'd2,  5'd2,  5'd1,  5'd0,  5'd8,  5'd10, 5'd12, 5'd15,
    5'd12, 5'd10, 5'd8,  5'd0,  5'd15, 5'd19, 5'd21, 5'd0
  };

  // Unknown note indices behave as rests.
  function automatic logic [16:0] half_period(input logic [7:0] note);
    if (note < 8'(NUM_NOTES)) begin
      return HALF_PERIOD[note[4:0]];
    end
    return '0;
  endfunction

  function automatic logic [4:0] song_at(input logic [5:0] idx);
    return SONG[idx];
  endfunction

endpackage

// File: rtl/bgm_tone_gen.sv
// Square-wave generator: counts a half-period down and toggles the level.
// hp is sampled on every reload (explicit or at each toggle), so a change
// of hp never shortens the half-cycle already in progress.
module bgm_tone_gen
  import bgm_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] hp,
  input  logic         enable,
  input  logic         reload,
  output logic         level
);

  logic [W-1:0] cnt;
  logic         active;

  // Half-period down-counter with level toggle; hp==0 parks the level at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      level  <= 1'b0;
      active <= 1'b0;
    end else if (reload) begin
      level  <= 1'b0;
      active <= (hp != '0);
      cnt    <= (hp != '0) ? hp - 1'b1 : '0;
    end else if (enable && active) begin
      if (cnt == '0) begin
        if (hp == '0) begin
          active <= 1'b0;
          level  <= 1'b0;
          cnt    <= '0;
        end else begin
          level <= ~level;
          cnt   <= hp - 1'b1;
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bgm_sequencer.sv
// Background-music sequencer: steps through the song table at a fixed
// tempo and drives a square-wave tone for the current note.
module bgm_sequencer
  import bgm_pkg::*;
#(
  parameter int STEP_CYCLES = 12500000,
  parameter int SONG_LEN    = 64,
  parameter int ADDR_W      = 6,
  parameter int NOTE_W      = 5,
  parameter int PERIOD_W    = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic              oct_up,
  input  logic              mute,
  output logic              audio_out,
  output logic              playing,
  output logic [ADDR_W-1:0] step_idx,
  output logic [NOTE_W-1:0] cur_note,
  output logic              done
);

  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0]     T_LAST    = TW'(STEP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(SONG_LEN - 1);

  function automatic logic [NOTE_W-1:0] song_note(input logic [ADDR_W-1:0] i);
    return NOTE_W'(song_at(6'(i)));
  endfunction

  state_t              state, state_n;
  logic [TW-1:0]       timer, timer_n;
  logic [ADDR_W-1:0]   step_n;
  logic [NOTE_W-1:0]   note_n, load_note, first_note;
  logic                done_n, reload, tick, tone_level;
  logic [PERIOD_W-1:0] hp;

  assign first_note = song_note('0);
  assign tick       = (state == PLAY) && (timer == T_LAST);

  // State, step timer, step index and note registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      step_idx <= '0;
      cur_note <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      step_idx <= step_n;
      cur_note <= note_n;
      done     <= done_n;
    end
  end

  // Next-state logic: stop > start > pause; step advance on timer tick.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    step_n    = step_idx;
    note_n    = cur_note;
    done_n    = 1'b0;
    reload    = 1'b0;
    load_note = cur_note;
    if (state != IDLE && stop) begin
      state_n = IDLE;
      timer_n = '0;
      step_n  = '0;
      note_n  = '0;
    end else if (start) begin
      // Start from IDLE and restart while playing share this path.
      state_n   = PLAY;
      timer_n   = '0;
      step_n    = '0;
      note_n    = first_note;
      reload    = 1'b1;
      load_note = first_note;
    end else if (state == PLAY) begin
      if (pause) state_n = PAUSE;
      timer_n = tick ? '0 : timer + 1'b1;
      if (tick) begin
        if (step_idx == LAST_STEP) begin
          if (loop_en) begin
            step_n    = '0;
            note_n    = first_note;
            reload    = 1'b1;
            load_note = first_note;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
            step_n  = '0;
            note_n  = '0;
            timer_n = '0;
          end
        end else begin
          step_n    = step_idx + 1'b1;
          note_n    = song_note(step_idx + 1'b1);
          reload    = 1'b1;
          load_note = note_n;
        end
      end
    end else if (state == PAUSE && !pause) begin
      state_n = PLAY;
    end
  end

  // Half-period for the note being loaded on a reload, else the sounding one.
  always_comb begin
    hp = PERIOD_W'(half_period(8'(reload ? load_note : cur_note)) >> oct_up);
  end

  bgm_tone_gen #(.W(PERIOD_W)) u_tone (
    .clk    (clk),
    .reset  (reset),
    .hp     (hp),
    .enable (state == PLAY),
    .reload (reload),
    .level  (tone_level)
  );

  assign playing   = (state != IDLE);
  assign audio_out = tone_level & (state == PLAY) & ~mute;

endmodule

// File: tb/tb_bgm_sequencer.sv
// Directed bench: a short-tempo 4-step instance for sequencing/FSM checks
// and a slow-tempo instance for exact tone period, octave, pause and mute.
module tb_bgm_sequencer;

  logic clk, reset;
  logic a_start, a_stop, a_pause, a_loop, a_oct, a_mute;
  logic a_audio, a_playing, a_done;
  logic [5:0] a_step;
  logic [4:0] a_note;
  logic b_start, b_stop, b_pause, b_loop, b_oct, b_mute;
  logic b_audio, b_playing, b_done;
  logic [5:0] b_step;
  logic [4:0] b_note;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  bgm_sequencer #(.STEP_CYCLES(16), .SONG_LEN(4), .ADDR_W(6), .NOTE_W(5), .PERIOD_W(17)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .stop(a_stop), .pause(a_pause),
    .loop_en(a_loop), .oct_up(a_oct), .mute(a_mute), .audio_out(a_audio),
    .playing(a_playing), .step_idx(a_step), .cur_note(a_note), .done(a_done)
  );

  bgm_sequencer #(.STEP_CYCLES(100000), .SONG_LEN(64), .ADDR_W(6), .NOTE_W(5), .PERIOD_W(17)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .stop(b_stop), .pause(b_pause),
    .loop_en(b_loop), .oct_up(b_oct), .mute(b_mute), .audio_out(b_audio),
    .playing(b_playing), .step_idx(b_step), .cur_note(b_note), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int unsigned target);
    while (cyc < target) tick();
  endtask

  task automatic start_a();
    a_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    cyc = 1;
  endtask

  function automatic int exp_note(input int s);
    case (s)
      0: return 6;
      1: return 8;
      2: return 0;
      default: return 15;
    endcase
  endfunction

  initial begin
    {a_start, a_stop, a_pause, a_loop, a_oct, a_mute} = '0;
    {b_start, b_stop, b_pause, b_loop, b_oct, b_mute} = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_audio", 32'(a_audio), 0);
    chk("rst_playing", 32'(a_playing), 0);
    chk("rst_step", 32'(a_step), 0);
    chk("rst_note", 32'(a_note), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_b_audio", 32'(b_audio), 0);
    chk("rst_b_playing", 32'(b_playing), 0);
    reset = 1'b0;
    tick();

    // One-shot: steps at cycles 1/17/33/49, done pulse only at cycle 65.
    a_loop = 1'b0;
    start_a();
    for (int c = 1; c <= 70; c++) begin
      if (c <= 64) begin
        chk("os_step", 32'(a_step), (c - 1) / 16);
        chk("os_note", 32'(a_note), exp_note((c - 1) / 16));
        chk("os_playing", 32'(a_playing), 1);
        chk("os_done", 32'(a_done), 0);
      end else begin
        chk("os_step_end", 32'(a_step), 0);
        chk("os_note_end", 32'(a_note), 0);
        chk("os_playing_end", 32'(a_playing), 0);
        chk("os_done_end", 32'(a_done), (c == 65) ? 1 : 0);
      end
      chk("os_audio", 32'(a_audio), 0);
      tick();
    end

    // Loop mode with mute: wraps to step 0 at cycle 65, no done.
    a_loop = 1'b1;
    a_mute = 1'b1;
    start_a();
    for (int c = 1; c <= 80; c++) begin
      chk("lp_step", 32'(a_step), ((c - 1) / 16) % 4);
      chk("lp_playing", 32'(a_playing), 1);
      chk("lp_done", 32'(a_done), 0);
      chk("lp_audio", 32'(a_audio), 0);
      tick();
    end

    // Asynchronous reset mid-play clears outputs within the cycle.
    run_to(101);
    chk("pre_rst_step", 32'(a_step), 2);
    reset = 1'b1;
    #1;
    chk("mid_rst_playing", 32'(a_playing), 0);
    chk("mid_rst_step", 32'(a_step), 0);
    chk("mid_rst_note", 32'(a_note), 0);
    chk("mid_rst_done", 32'(a_done), 0);
    chk("mid_rst_audio", 32'(a_audio), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    a_mute = 1'b0;
    tick();
    chk("post_rst_done", 32'(a_done), 0);
    chk("post_rst_playing", 32'(a_playing), 0);
    start_a();
    chk("rst_start_step", 32'(a_step), 0);
    chk("rst_start_note", 32'(a_note), 6);
    chk("rst_start_playing", 32'(a_playing), 1);

    // Restart while playing returns to step 0 with a fresh step timer.
    run_to(40);
    chk("rs_pre_step", 32'(a_step), 2);
    start_a();
    chk("rs_step", 32'(a_step), 0);
    chk("rs_note", 32'(a_note), 6);
    run_to(16);
    chk("rs_step16", 32'(a_step), 0);
    tick();
    chk("rs_step17", 32'(a_step), 1);

    // Pause for 10 cycles delays the step tick by exactly 10 cycles.
    start_a();
    run_to(5);
    a_pause = 1'b1;
    repeat (10) begin
      tick();
      chk("ps_playing", 32'(a_playing), 1);
      chk("ps_audio", 32'(a_audio), 0);
      chk("ps_step", 32'(a_step), 0);
    end
    a_pause = 1'b0;
    run_to(26);
    chk("ps_step26", 32'(a_step), 0);
    tick();
    chk("ps_step27", 32'(a_step), 1);
    chk("ps_note27", 32'(a_note), 8);

    // Stop returns to IDLE without done; stop beats a simultaneous start.
    a_stop = 1'b1;
    tick();
    a_stop = 1'b0;
    chk("stop_playing", 32'(a_playing), 0);
    chk("stop_step", 32'(a_step), 0);
    chk("stop_done", 32'(a_done), 0);
    start_a();
    a_start = 1'b1;
    a_stop = 1'b1;
    tick();
    a_start = 1'b0;
    a_stop = 1'b0;
    chk("prio_playing", 32'(a_playing), 0);

    // Tone: note 6 half-period 56818, then octave up (28409) with a
    // 10-cycle pause inside that half-cycle and a brief mute.
    b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    cyc = 1;
    chk("tone_note", 32'(b_note), 6);
    chk("tone_audio0", 32'(b_audio), 0);
    run_to(100);
    b_oct = 1'b1;
    run_to(56818);
    chk("tone_a4_before", 32'(b_audio), 0);
    tick();
    chk("tone_a4_edge", 32'(b_audio), 1);
    run_to(56830);
    chk("tone_hi", 32'(b_audio), 1);
    b_pause = 1'b1;
    repeat (10) begin
      tick();
      chk("tone_pause_audio", 32'(b_audio), 0);
      chk("tone_pause_playing", 32'(b_playing), 1);
    end
    b_pause = 1'b0;
    tick();
    chk("tone_resume", 32'(b_audio), 1);
    run_to(56850);
    b_mute = 1'b1;
    tick();
    chk("tone_mute", 32'(b_audio), 0);
    b_mute = 1'b0;
    #1;
    chk("tone_unmute", 32'(b_audio), 1);
    run_to(85237);
    chk("tone_oct_before", 32'(b_audio), 1);
    tick();
    chk("tone_oct_edge", 32'(b_audio), 0);
    chk("tone_step", 32'(b_step), 0);
    chk("tone_done", 32'(b_done), 0);
    b_stop = 1'b1;
    tick();
    b_stop = 1'b0;
    chk("tone_stop_playing", 32'(b_playing), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
